// File: rtl/int8_divmod.sv
// Sequential unsigned 8-bit divider: restoring shift-subtract, one quotient bit per clock.
// Results are registered and held until the next accepted start.
module int8_divmod (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_zero
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] q_q, q_d;
    logic [8:0] r_q, r_d;
    logic [7:0] b_q, b_d;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] quotient_q, quotient_d;
    logic [7:0] remainder_q, remainder_d;
    logic       div_zero_q, div_zero_d;

    logic [8:0] trial;
    logic [8:0] diff;
    logic       no_borrow;
    logic [7:0] q_step;
    logic [8:0] r_step;

    always_comb begin
        trial     = {r_q[7:0], q_q[7]};
        diff      = trial - {1'b0, b_q};
        no_borrow = (trial >= {1'b0, b_q});
        q_step    = {q_q[6:0], no_borrow};
        r_step    = no_borrow ? diff : trial;
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            StIdle, StDone: begin
                // DONE accepts a new request exactly like IDLE for back-to-back use
                if (start) begin
                    if (b != 8'd0) begin
                        state_d = StRun;
                        q_d     = a;
                        r_d     = 9'd0;
                        b_d     = b;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d     = StDone;
                        quotient_d  = 8'hFF;
                        remainder_d = a;
                        div_zero_d  = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d     = StDone;
                    quotient_d  = q_step;
                    remainder_d = r_step[7:0];
                    div_zero_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            q_q         <= 8'd0;
            r_q         <= 9'd0;
            b_q         <= 8'd0;
            cnt_q       <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_int8_divmod.sv
// Directed self-checking bench for int8_divmod; inputs driven and outputs sampled on negedge.
module tb_int8_divmod;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    int8_divmod dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " quotient"}, 32'(quotient), 32'd0);
        check({tag, " remainder"}, 32'(remainder), 32'd0);
        check({tag, " div_zero"}, 32'(div_zero), 32'd0);
    endtask

    // Called on a negedge; returns on the negedge where done should be high.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_q, input logic [7:0] exp_r, input bit full);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (full) begin
                check({tag, " busy in run"}, 32'(busy), 32'd1);
                check({tag, " no done in run"}, 32'(done), 32'd0);
            end
            @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
        if (full) begin
            check({tag, " busy at done"}, 32'(busy), 32'd0);
            check({tag, " div_zero"}, 32'(div_zero), 32'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("idle after reset");

        run_op("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b1);
        @(negedge clk);
        check("done one cycle", 32'(done), 32'd0);
        check("result held q", 32'(quotient), 32'd14);
        check("result held r", 32'(remainder), 32'd2);

        run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b1);
        run_op("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b1);
        run_op("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b1);
        run_op("0/3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b1);
        @(negedge clk);

        // Divide by zero: one-cycle turnaround, busy never rises
        a     = 8'd7;
        b     = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("div0 done", 32'(done), 32'd1);
        check("div0 busy", 32'(busy), 32'd0);
        check("div0 quotient", 32'(quotient), 32'hFF);
        check("div0 remainder", 32'(remainder), 32'd7);
        check("div0 flag", 32'(div_zero), 32'd1);
        @(negedge clk);
        check("div0 done pulse ends", 32'(done), 32'd0);
        check("div0 busy stays low", 32'(busy), 32'd0);
        run_op("9/3 after div0", 8'd9, 8'd3, 8'd3, 8'd0, 1'b1);
        @(negedge clk);

        // Start during RUN must be ignored
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a     = 8'd50;
        b     = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("ignored start no early done", 32'(done), 32'd0);
        @(negedge clk);
        check("ignored start done", 32'(done), 32'd1);
        check("ignored start quotient", 32'(quotient), 32'd14);
        check("ignored start remainder", 32'(remainder), 32'd2);
        @(negedge clk);

        // Back-to-back: start held, operands swapped in the DONE cycle
        a     = 8'd200;
        b     = 8'd3;
        start = 1'b1;
        repeat (9) @(negedge clk);
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first quotient", 32'(quotient), 32'd66);
        check("b2b first remainder", 32'(remainder), 32'd2);
        a = 8'd17;
        b = 8'd4;
        @(negedge clk);
        start = 1'b0;
        check("b2b straight into run", 32'(busy), 32'd1);
        check("b2b done low", 32'(done), 32'd0);
        repeat (8) @(negedge clk);
        check("b2b second done", 32'(done), 32'd1);
        check("b2b second quotient", 32'(quotient), 32'd4);
        check("b2b second remainder", 32'(remainder), 32'd1);
        @(negedge clk);

        // Reset mid-RUN aborts with no done pulse
        a     = 8'd100;
        b     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy before abort", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort");
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) check("no done after abort", 32'(done), 32'd0);
            @(negedge clk);
        end
        run_op("9/2 after abort", 8'd9, 8'd2, 8'd4, 8'd1, 1'b1);

        // Sampled sweep against the arithmetic reference
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 21; j++) begin
                logic [7:0] av;
                logic [7:0] bv;
                av = 8'(i * 17);
                bv = (j == 20) ? 8'd255 : 8'(1 + j * 13);
                run_op($sformatf("sweep %0d/%0d", av, bv), av, bv, av / bv, av % bv, 1'b0);
            end
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
